// File: rtl/redmule_tile_ctrl.sv
// Purpose: tile-level sequencer for RedMulE (W load, drain, Z fill/store over N tiles, 1-2 Z buffers).
// Latency: outputs decode from registered state; z_fill_o is combinational from reg_enable_i in BUFFERING.
// Backpressure: stalls in WAIT_BUF/WAIT_STORE until the store side empties the needed Z buffer.
// Ports: clk_i/rst_i/clear_i (sync, active-high); start_i + cfg_* (captured at start);
//        reg_enable_i, w_loaded_i, z_full_i, z_empty_i from engine/buffers;
//        busy/done/first_load/w_shift/z_fill/z_buf_sel/store_req/store_buf/accumulate/flush/tile_cnt out.
module redmule_tile_ctrl #(
    parameter int unsigned Height   = 4,
    parameter int unsigned CntWidth = 16,
    parameter int unsigned NumZBuf  = 2,
    localparam int unsigned BufIdxW = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear_i,
    input  logic                start_i,
    input  logic [CntWidth-1:0] cfg_w_rows_i,
    input  logic [CntWidth-1:0] cfg_tot_stores_i,
    input  logic                cfg_acc_init_i,
    input  logic                reg_enable_i,
    input  logic                w_loaded_i,
    input  logic [NumZBuf-1:0]  z_full_i,
    input  logic [NumZBuf-1:0]  z_empty_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                first_load_o,
    output logic                w_shift_o,
    output logic                z_fill_o,
    output logic [BufIdxW-1:0]  z_buf_sel_o,
    output logic                store_req_o,
    output logic [BufIdxW-1:0]  store_buf_o,
    output logic                accumulate_o,
    output logic                flush_o,
    output logic [CntWidth-1:0] tile_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_STARTING, S_COMPUTING, S_DRAIN,
        S_BUFFERING, S_WAIT_BUF, S_WAIT_STORE, S_FINISHED
    } state_e;

    state_e                state, state_nxt;
    logic [CntWidth-1:0]   cfg_w_rows, cfg_tot_stores;
    logic                  cfg_acc_init;
    logic [CntWidth-1:0]   row_cnt, row_nxt, row_inc;
    logic [CntWidth-1:0]   drain_cnt, drain_nxt;
    logic [CntWidth-1:0]   acc_cnt, acc_nxt;
    logic [CntWidth-1:0]   filled, filled_nxt;
    logic [CntWidth-1:0]   tile_cnt;
    logic [NumZBuf-1:0]    pending, pending_nxt, store_mask, fill_mask;
    logic [NumZBuf-1:0]    z_empty_q;
    logic [BufIdxW-1:0]    fill_ptr, fill_ptr_nxt, fill_ptr_inc;
    logic [BufIdxW-1:0]    store_ptr, store_ptr_inc;
    logic                  store_hit, fill_hit;

    // With a single buffer both pointers stay at 0.
    assign fill_ptr_inc  = (NumZBuf > 1) ? fill_ptr + 1'b1 : '0;
    assign store_ptr_inc = (NumZBuf > 1) ? store_ptr + 1'b1 : '0;

    // W-row prefetch counter saturates at the configured row count.
    assign row_inc = (w_loaded_i && (row_cnt != cfg_w_rows)) ? row_cnt + 1'b1 : row_cnt;

    // Fill and store events on the pending mask; both apply in the same cycle.
    always_comb begin
        store_hit  = pending[store_ptr] & z_empty_i[store_ptr] & ~z_empty_q[store_ptr];
        fill_hit   = (state == S_BUFFERING) & z_full_i[fill_ptr];
        store_mask = '0;
        fill_mask  = '0;
        if (store_hit) store_mask[store_ptr] = 1'b1;
        if (fill_hit)  fill_mask[fill_ptr]   = 1'b1;
        pending_nxt = (pending & ~store_mask) | fill_mask;
    end

    always_comb begin
        state_nxt    = state;
        row_nxt      = row_cnt;
        drain_nxt    = drain_cnt;
        acc_nxt      = acc_cnt;
        filled_nxt   = filled;
        fill_ptr_nxt = fill_ptr;
        if ((state == S_COMPUTING || state == S_DRAIN) && reg_enable_i
            && acc_cnt != CntWidth'(Height)) begin
            acc_nxt = acc_cnt + 1'b1;
        end
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    state_nxt = (cfg_tot_stores_i == '0) ? S_FINISHED : S_STARTING;
                end
            end
            S_STARTING: begin
                if (w_loaded_i) begin
                    state_nxt = S_COMPUTING;
                    row_nxt   = CntWidth'(1);
                end
            end
            S_COMPUTING: begin
                if (row_cnt == cfg_w_rows) begin
                    state_nxt = S_DRAIN;
                    row_nxt   = '0;
                    drain_nxt = '0;
                end else begin
                    row_nxt = row_inc;
                end
            end
            S_DRAIN: begin
                row_nxt = row_inc;
                if (reg_enable_i) begin
                    drain_nxt = drain_cnt + 1'b1;
                    // Height-1 enables flush the array pipeline.
                    if (drain_cnt == CntWidth'(Height - 2)) state_nxt = S_BUFFERING;
                end
            end
            S_BUFFERING: begin
                row_nxt = row_inc;
                if (fill_hit) begin
                    filled_nxt   = filled + 1'b1;
                    fill_ptr_nxt = fill_ptr_inc;
                    if (filled + 1'b1 == cfg_tot_stores) begin
                        state_nxt = S_WAIT_STORE;
                    end else if (pending_nxt[fill_ptr_inc]) begin
                        state_nxt = S_WAIT_BUF;
                    end else begin
                        state_nxt = S_COMPUTING;
                        acc_nxt   = '0;
                    end
                end
            end
            S_WAIT_BUF: begin
                row_nxt = row_inc;
                // Same-cycle empty edge on the awaited buffer releases immediately.
                if (!pending_nxt[fill_ptr]) begin
                    state_nxt = S_COMPUTING;
                    acc_nxt   = '0;
                end
            end
            S_WAIT_STORE: begin
                if (pending == '0) state_nxt = S_FINISHED;
            end
            default: begin
                state_nxt    = S_IDLE;
                row_nxt      = '0;
                drain_nxt    = '0;
                acc_nxt      = '0;
                filled_nxt   = '0;
                fill_ptr_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state          <= S_IDLE;
            cfg_w_rows     <= '0;
            cfg_tot_stores <= '0;
            cfg_acc_init   <= 1'b0;
            row_cnt        <= '0;
            drain_cnt      <= '0;
            acc_cnt        <= '0;
            filled         <= '0;
            tile_cnt       <= '0;
            pending        <= '0;
            fill_ptr       <= '0;
            store_ptr      <= '0;
            z_empty_q      <= '0;
        end else begin
            state     <= state_nxt;
            row_cnt   <= row_nxt;
            drain_cnt <= drain_nxt;
            acc_cnt   <= acc_nxt;
            filled    <= filled_nxt;
            fill_ptr  <= fill_ptr_nxt;
            z_empty_q <= z_empty_i;
            if (state == S_IDLE && start_i) begin
                cfg_w_rows     <= cfg_w_rows_i;
                cfg_tot_stores <= cfg_tot_stores_i;
                cfg_acc_init   <= cfg_acc_init_i;
            end
            if (state == S_FINISHED) begin
                pending   <= '0;
                store_ptr <= '0;
                tile_cnt  <= '0;
            end else begin
                pending <= pending_nxt;
                if (store_hit) begin
                    store_ptr <= store_ptr_inc;
                    tile_cnt  <= tile_cnt + 1'b1;
                end
            end
        end
    end

    assign busy_o       = (state != S_IDLE) && (state != S_FINISHED);
    assign done_o       = (state == S_FINISHED);
    assign flush_o      = (state == S_FINISHED);
    assign first_load_o = (state == S_STARTING);
    assign w_shift_o    = (state == S_COMPUTING) || (state == S_DRAIN) || (state == S_BUFFERING)
                          || (state == S_WAIT_BUF) || (state == S_WAIT_STORE);
    assign z_fill_o     = (state == S_BUFFERING) && reg_enable_i;
    assign z_buf_sel_o  = fill_ptr;
    assign store_req_o  = pending[store_ptr];
    assign store_buf_o  = store_ptr;
    assign accumulate_o = ((state == S_COMPUTING) || (state == S_DRAIN))
                          && (cfg_acc_init || acc_cnt == CntWidth'(Height));
    assign tile_cnt_o   = tile_cnt;

endmodule

// File: tb/tb_redmule_tile_ctrl.sv
// Bench for redmule_tile_ctrl: instance a (two Z buffers) and instance b (one Z buffer)
// share all inputs except start; a per-cycle reference model predicts both output sets,
// and directed scenarios add hand-computed literal checks.
module tb_redmule_tile_ctrl;
    localparam int H = 4;
    localparam int P_IDLE = 0, P_START = 1, P_COMP = 2, P_DRAIN = 3,
                   P_BUF = 4, P_WBUF = 5, P_WST = 6, P_FIN = 7;

    logic clk = 1'b0;
    logic rst, clear, start_a, start_b, acc_init, reg_enable, w_loaded;
    logic [15:0] w_rows, tot_stores;
    logic [1:0]  z_full, z_empty;

    logic a_busy, a_done, a_first_load, a_w_shift, a_z_fill, a_z_buf_sel;
    logic a_store_req, a_store_buf, a_acc, a_flush;
    logic [15:0] a_tile;
    logic b_busy, b_done, b_first_load, b_w_shift, b_z_fill, b_z_buf_sel;
    logic b_store_req, b_store_buf, b_acc, b_flush;
    logic [15:0] b_tile;

    int vectors = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    redmule_tile_ctrl #(.Height(H), .CntWidth(16), .NumZBuf(2)) u_a (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .start_i(start_a),
        .cfg_w_rows_i(w_rows), .cfg_tot_stores_i(tot_stores), .cfg_acc_init_i(acc_init),
        .reg_enable_i(reg_enable), .w_loaded_i(w_loaded), .z_full_i(z_full), .z_empty_i(z_empty),
        .busy_o(a_busy), .done_o(a_done), .first_load_o(a_first_load), .w_shift_o(a_w_shift),
        .z_fill_o(a_z_fill), .z_buf_sel_o(a_z_buf_sel), .store_req_o(a_store_req),
        .store_buf_o(a_store_buf), .accumulate_o(a_acc), .flush_o(a_flush), .tile_cnt_o(a_tile));

    redmule_tile_ctrl #(.Height(H), .CntWidth(16), .NumZBuf(1)) u_b (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .start_i(start_b),
        .cfg_w_rows_i(w_rows), .cfg_tot_stores_i(tot_stores), .cfg_acc_init_i(acc_init),
        .reg_enable_i(reg_enable), .w_loaded_i(w_loaded), .z_full_i(z_full[0:0]), .z_empty_i(z_empty[0:0]),
        .busy_o(b_busy), .done_o(b_done), .first_load_o(b_first_load), .w_shift_o(b_w_shift),
        .z_fill_o(b_z_fill), .z_buf_sel_o(b_z_buf_sel), .store_req_o(b_store_req),
        .store_buf_o(b_store_buf), .accumulate_o(b_acc), .flush_o(b_flush), .tile_cnt_o(b_tile));

    // ---------------- reference model (index 0 = instance a, 1 = instance b) ----------------
    int m_ph[2], m_wr[2], m_ts[2], m_ai[2], m_rows[2], m_drn[2], m_acc[2];
    int m_filled[2], m_tiles[2], m_fp[2], m_sp[2];
    bit [1:0] m_pend[2], m_zeq[2];

    task automatic mstep(input int k);
        int nz, rinc;
        bit st, hit;
        bit [1:0] zf, ze, np;
        nz = (k == 0) ? 2 : 1;
        st = (k == 0) ? start_a : start_b;
        zf = (k == 0) ? z_full  : {1'b0, z_full[0]};
        ze = (k == 0) ? z_empty : {1'b0, z_empty[0]};
        if (rst || clear) begin
            m_ph[k] = P_IDLE; m_wr[k] = 0; m_ts[k] = 0; m_ai[k] = 0; m_rows[k] = 0;
            m_drn[k] = 0; m_acc[k] = 0; m_filled[k] = 0; m_tiles[k] = 0;
            m_fp[k] = 0; m_sp[k] = 0; m_pend[k] = 0; m_zeq[k] = 0;
            return;
        end
        np  = m_pend[k];
        hit = np[m_sp[k]] && ze[m_sp[k]] && !m_zeq[k][m_sp[k]];
        if (hit) begin
            np[m_sp[k]] = 1'b0;
            m_tiles[k]++;
            m_sp[k] = (m_sp[k] + 1) % nz;
        end
        rinc = (w_loaded && m_rows[k] < m_wr[k]) ? m_rows[k] + 1 : m_rows[k];
        if ((m_ph[k] == P_COMP || m_ph[k] == P_DRAIN) && reg_enable && m_acc[k] < H) m_acc[k]++;
        case (m_ph[k])
            P_IDLE: if (st) begin
                m_wr[k] = int'(w_rows); m_ts[k] = int'(tot_stores); m_ai[k] = int'(acc_init);
                m_ph[k] = (tot_stores == 0) ? P_FIN : P_START;
            end
            P_START: if (w_loaded) begin m_rows[k] = 1; m_ph[k] = P_COMP; end
            P_COMP: if (m_rows[k] == m_wr[k]) begin
                m_rows[k] = 0; m_drn[k] = 0; m_ph[k] = P_DRAIN;
            end else m_rows[k] = rinc;
            P_DRAIN: begin
                m_rows[k] = rinc;
                if (reg_enable) begin
                    if (m_drn[k] == H - 2) m_ph[k] = P_BUF;
                    m_drn[k]++;
                end
            end
            P_BUF: begin
                m_rows[k] = rinc;
                if (zf[m_fp[k]]) begin
                    np[m_fp[k]] = 1'b1;
                    m_filled[k]++;
                    m_fp[k] = (m_fp[k] + 1) % nz;
                    if (m_filled[k] == m_ts[k]) m_ph[k] = P_WST;
                    else if (np[m_fp[k]]) m_ph[k] = P_WBUF;
                    else begin m_ph[k] = P_COMP; m_acc[k] = 0; end
                end
            end
            P_WBUF: begin
                m_rows[k] = rinc;
                if (!np[m_fp[k]]) begin m_ph[k] = P_COMP; m_acc[k] = 0; end
            end
            P_WST: if (m_pend[k] == 0) m_ph[k] = P_FIN;
            default: begin
                m_rows[k] = 0; m_drn[k] = 0; m_acc[k] = 0; m_filled[k] = 0;
                m_tiles[k] = 0; m_fp[k] = 0; m_sp[k] = 0; np = 0; m_ph[k] = P_IDLE;
            end
        endcase
        m_pend[k] = np;
        m_zeq[k]  = ze;
    endtask

    function automatic logic [25:0] mexp(input int k);
        int p;
        bit active;
        p = m_ph[k];
        active = (p == P_COMP) || (p == P_DRAIN);
        return {p != P_IDLE && p != P_FIN, p == P_FIN, p == P_START,
                p == P_COMP || p == P_DRAIN || p == P_BUF || p == P_WBUF || p == P_WST,
                p == P_BUF && reg_enable == 1'b1, 1'(m_fp[k]), m_pend[k][m_sp[k]], 1'(m_sp[k]),
                active && (m_ai[k] != 0 || m_acc[k] == H), p == P_FIN, 16'(m_tiles[k])};
    endfunction

    always @(posedge clk) begin
        mstep(0);
        mstep(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cycle_a", {a_busy, a_done, a_first_load, a_w_shift, a_z_fill, a_z_buf_sel,
                            a_store_req, a_store_buf, a_acc, a_flush, a_tile}, 32'(mexp(0)));
            chk("cycle_b", {b_busy, b_done, b_first_load, b_w_shift, b_z_fill, b_z_buf_sel,
                            b_store_req, b_store_buf, b_acc, b_flush, b_tile}, 32'(mexp(1)));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; clear = 1'b0; start_a = 1'b0; start_b = 1'b0; acc_init = 1'b0;
        reg_enable = 1'b0; w_loaded = 1'b0; w_rows = 16'd0; tot_stores = 16'd0;
        z_full = 2'b00; z_empty = 2'b00;
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic wait_fill_a(input string nm);
        for (int i = 0; i < 60 && !a_z_fill; i++) step();
        chk(nm, 32'(a_z_fill), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state of both instances.
        do_reset();
        chk("reset_a", {a_busy, a_done, a_first_load, a_w_shift, a_z_fill, a_z_buf_sel,
                        a_store_req, a_store_buf, a_acc, a_flush, a_tile}, 32'd0);
        chk("reset_b", {b_busy, b_done, b_first_load, b_w_shift, b_z_fill, b_z_buf_sel,
                        b_store_req, b_store_buf, b_acc, b_flush, b_tile}, 32'd0);

        // S1: single buffer, 8 rows, 1 tile.
        w_rows = 16'd8; tot_stores = 16'd1; acc_init = 1'b0; reg_enable = 1'b1;
        start_b = 1'b1; step(); start_b = 1'b0;
        chk("s1_start", {b_busy, b_first_load}, 32'b11);
        w_loaded = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 3) chk("s1_acc_pre", 32'(b_acc), 32'd0);
            if (i == 4) chk("s1_acc_rise", 32'(b_acc), 32'd1);
        end
        w_loaded = 1'b0;
        step(); step(); step();
        chk("s1_drain_end", {b_acc, b_z_fill}, 32'b10);
        step();
        chk("s1_buffering", {b_acc, b_z_fill}, 32'b01);
        z_full = 2'b01; step(); z_full = 2'b00;
        chk("s1_store_req", 32'(b_store_req), 32'd1);
        z_empty = 2'b01; step();
        chk("s1_tile", {b_tile, b_done}, {15'd0, 16'd1, 1'b0});
        step();
        chk("s1_done", {b_done, b_busy, b_flush}, 32'b101);
        step();
        chk("s1_idle", {b_busy, b_done, b_tile}, 32'd0);

        // S2: two buffers, 3 tiles, accumulate-on-init, overlapped store.
        do_reset();
        w_rows = 16'd2; tot_stores = 16'd3; acc_init = 1'b1; reg_enable = 1'b1; w_loaded = 1'b1;
        start_a = 1'b1; step(); start_a = 1'b0;
        chk("s2_first_load", 32'(a_first_load), 32'd1);
        step();
        chk("s2_acc_init", 32'(a_acc), 32'd1);
        wait_fill_a("s2_fill0");
        z_full = 2'b01; step(); z_full = 2'b00;
        chk("s2_overlap0", {a_store_req, a_store_buf, a_acc, a_z_fill}, 32'b1010);
        z_empty = 2'b01; step(); z_empty = 2'b00;
        chk("s2_tile1", 32'(a_tile), 32'd1);
        wait_fill_a("s2_fill1");
        chk("s2_sel1", 32'(a_z_buf_sel), 32'd1);
        z_full = 2'b10; step(); z_full = 2'b00;
        chk("s2_overlap1", {a_store_req, a_store_buf, a_acc, a_z_fill}, 32'b1110);
        z_empty = 2'b10; step(); z_empty = 2'b00;
        chk("s2_tile2", 32'(a_tile), 32'd2);
        wait_fill_a("s2_fill2");
        z_full = 2'b01; step(); z_full = 2'b00;
        chk("s2_wait_store", {a_busy, a_acc, a_store_req, a_store_buf}, 32'b1010);
        z_empty = 2'b01; step(); z_empty = 2'b00;
        chk("s2_tile3", {a_tile, a_done}, {15'd0, 16'd3, 1'b0});
        step();
        chk("s2_done", {a_done, a_tile}, {15'd0, 1'b1, 16'd3});
        step();
        chk("s2_idle", {a_busy, a_done, a_tile}, 32'd0);

        // S3: buffer 0 held full -> WAIT_BUF; start during BUFFERING ignored.
        do_reset();
        w_rows = 16'd2; tot_stores = 16'd3; acc_init = 1'b1; reg_enable = 1'b1; w_loaded = 1'b1;
        start_a = 1'b1; step(); start_a = 1'b0;
        wait_fill_a("s3_fill0");
        start_a = 1'b1; tot_stores = 16'd1; step(); start_a = 1'b0;
        chk("s3_start_ignored", {a_busy, a_first_load, a_z_fill}, 32'b101);
        z_full = 2'b01; step(); z_full = 2'b00;
        wait_fill_a("s3_fill1");
        z_full = 2'b10; step(); z_full = 2'b00;
        chk("s3_wait_buf", {a_busy, a_w_shift, a_acc, a_z_fill, a_store_req, a_store_buf}, 32'b110010);
        for (int i = 0; i < 5; i++) step();
        chk("s3_hold", {a_busy, a_w_shift, a_acc, a_z_fill, a_store_req, a_store_buf}, 32'b110010);
        z_empty = 2'b01; step(); z_empty = 2'b00;
        chk("s3_resume", {a_acc, a_tile, a_store_buf}, {14'd0, 1'b1, 16'd1, 1'b1});

        // S4: zero tiles -> done at t+1, never busy.
        do_reset();
        tot_stores = 16'd0; w_rows = 16'd1;
        start_a = 1'b1; step(); start_a = 1'b0;
        chk("s4_done", {a_done, a_busy, a_flush}, 32'b101);
        step();
        chk("s4_idle", {a_done, a_busy}, 32'b00);

        // S5: clear in DRAIN, then a normal job.
        do_reset();
        w_rows = 16'd1; tot_stores = 16'd1; acc_init = 1'b0; reg_enable = 1'b1;
        start_a = 1'b1; step(); start_a = 1'b0;
        w_loaded = 1'b1; step(); w_loaded = 1'b0;
        step();
        chk("s5_in_drain", {a_busy, a_w_shift, a_z_fill, a_first_load}, 32'b1100);
        clear = 1'b1; step(); clear = 1'b0;
        chk("s5_cleared", {a_busy, a_done, a_first_load, a_w_shift, a_z_fill, a_z_buf_sel,
                           a_store_req, a_store_buf, a_acc, a_flush, a_tile}, 32'd0);
        start_a = 1'b1; step(); start_a = 1'b0;
        w_loaded = 1'b1; step(); w_loaded = 1'b0;
        wait_fill_a("s5_fill");
        z_full = 2'b01; step(); z_full = 2'b00;
        z_empty = 2'b01; step(); z_empty = 2'b00;
        for (int i = 0; i < 10 && !a_done; i++) step();
        chk("s5_done", {a_done, a_tile}, {15'd0, 1'b1, 16'd1});
        step();
        chk("s5_idle", {a_busy, a_done}, 32'b00);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
